// File: rtl/lfsr_monitor.sv
// Health checker for a maximal-length LFSR: measures cycles between max_tick pulses,
// flags timeouts, and (with LFSR_MONITOR_STUCK_EN defined) flags a stuck LFSR value.
module lfsr_monitor #(
  parameter int WIDTH           = 12,
  parameter int EXPECTED_PERIOD = 4095,
  parameter int LOCKUP_LIMIT    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] lfsr_in,
  input  logic             max_tick_in,
  output logic [WIDTH:0]   period_out,
  output logic             period_valid,
  output logic             period_ok,
  output logic [7:0]       good_count,
  output logic [7:0]       bad_count,
  output logic             measuring,
  output logic             fault,
  output logic [1:0]       fault_code
);

  localparam logic [WIDTH:0] CNT_MAX    = {(WIDTH+1){1'b1}};
  localparam logic [WIDTH:0] EXP_PERIOD = (WIDTH+1)'(EXPECTED_PERIOD);

  if (LOCKUP_LIMIT < 2) begin : g_limit_chk
    $error("LOCKUP_LIMIT must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_FAULT   = 2'd2
  } state_t;

  state_t         state_q;
  logic [WIDTH:0] cnt_q;
  logic [WIDTH:0] cnt_d;
  logic [WIDTH:0] period_q;
  logic           period_valid_q;
  logic           period_ok_q;
  logic [7:0]     good_q;
  logic [7:0]     bad_q;
  logic           measuring_q;
  logic           fault_q;
  logic [1:0]     fault_code_q;
  logic           stuck;

  assign cnt_d = cnt_q + (WIDTH+1)'(1);

`ifdef LFSR_MONITOR_STUCK_EN
  localparam int RW = $clog2(LOCKUP_LIMIT);

  logic [WIDTH-1:0] prev_q;
  logic             prev_vld_q;
  logic [RW-1:0]    run_q;
  logic             same;

  // run_q counts repeats, so LOCKUP_LIMIT identical samples means LOCKUP_LIMIT-1 repeats
  assign same  = prev_vld_q && (lfsr_in == prev_q);
  assign stuck = same && (run_q == RW'(LOCKUP_LIMIT - 2));

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      run_q      <= '0;
    end else if (state_q != S_FAULT) begin
      prev_q     <= lfsr_in;
      prev_vld_q <= 1'b1;
      run_q      <= same ? run_q + RW'(1) : '0;
    end
  end
`else
  logic lfsr_in_unused;
  assign lfsr_in_unused = ^lfsr_in;
  assign stuck          = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      period_ok_q    <= 1'b0;
      good_q         <= '0;
      bad_q          <= '0;
      measuring_q    <= 1'b0;
      fault_q        <= 1'b0;
      fault_code_q   <= 2'b00;
    end else begin
      period_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (stuck) begin
            state_q      <= S_FAULT;
            fault_q      <= 1'b1;
            fault_code_q <= 2'b10;
          end else if (max_tick_in) begin
            state_q     <= S_MEASURE;
            cnt_q       <= (WIDTH+1)'(1);
            measuring_q <= 1'b1;
          end
        end
        S_MEASURE: begin
          // stuck beats both a tick and a timeout; a tick beats the timeout
          if (stuck) begin
            state_q      <= S_FAULT;
            measuring_q  <= 1'b0;
            fault_q      <= 1'b1;
            fault_code_q <= 2'b10;
          end else if (max_tick_in) begin
            period_q       <= cnt_q;
            period_valid_q <= 1'b1;
            period_ok_q    <= (cnt_q == EXP_PERIOD);
            if (cnt_q == EXP_PERIOD) begin
              if (good_q != 8'hFF) good_q <= good_q + 8'd1;
            end else begin
              if (bad_q != 8'hFF) bad_q <= bad_q + 8'd1;
            end
            cnt_q <= (WIDTH+1)'(1);
          end else if (cnt_q == CNT_MAX) begin
            state_q      <= S_FAULT;
            measuring_q  <= 1'b0;
            fault_q      <= 1'b1;
            fault_code_q <= 2'b01;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: begin
          // FAULT holds everything until reset
          state_q <= S_FAULT;
        end
      endcase
    end
  end

  assign period_out   = period_q;
  assign period_valid = period_valid_q;
  assign period_ok    = period_ok_q;
  assign good_count   = good_q;
  assign bad_count    = bad_q;
  assign measuring    = measuring_q;
  assign fault        = fault_q;
  assign fault_code   = fault_code_q;

endmodule

// File: tb/tb_lfsr_monitor.sv
// Scoreboard bench for lfsr_monitor: stimulus pushes expected period reports,
// a negedge monitor pops and compares on every period_valid.
module tb_lfsr_monitor;
  localparam int W = 12;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] lfsr_in = '0;
  logic         max_tick_in = 1'b0;
  logic [W:0]   period_out;
  logic         period_valid;
  logic         period_ok;
  logic [7:0]   good_count;
  logic [7:0]   bad_count;
  logic         measuring;
  logic         fault;
  logic [1:0]   fault_code;

  lfsr_monitor #(.WIDTH(W), .EXPECTED_PERIOD(4095), .LOCKUP_LIMIT(16)) dut (
    .clk(clk), .reset(reset), .lfsr_in(lfsr_in), .max_tick_in(max_tick_in),
    .period_out(period_out), .period_valid(period_valid), .period_ok(period_ok),
    .good_count(good_count), .bad_count(bad_count), .measuring(measuring),
    .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int period;
    int ok;
    int good;
    int bad;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;
  bit   hold   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic push(input int p, input int ok, input int g, input int b);
    exp_t e;
    e.period = p; e.ok = ok; e.good = g; e.bad = b;
    q.push_back(e);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (period_valid) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_period_valid: got period %0d, expected no report", period_out);
      end else begin
        e = q.pop_front();
        chk("sb_period_out", int'(period_out), e.period);
        chk("sb_period_ok", int'(period_ok), e.ok);
        chk("sb_good_count", int'(good_count), e.good);
        chk("sb_bad_count", int'(bad_count), e.bad);
      end
    end
  end

  // one clock edge with the given tick; lfsr_in keeps changing unless held
  task automatic cyc(input bit tk);
    max_tick_in = tk;
    if (!hold) lfsr_in = lfsr_in + 1'b1;
    @(posedge clk);
    #1;
    max_tick_in = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cyc(1'b0);
    reset = 1'b0;
  endtask

  task automatic ticks(input int n, input int p);
    for (int i = 0; i < n; i++) begin
      if (i > 0) repeat (p - 1) cyc(1'b0);
      cyc(1'b1);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_period_out"}, int'(period_out), 0);
    chk({tag, "_period_valid"}, int'(period_valid), 0);
    chk({tag, "_period_ok"}, int'(period_ok), 0);
    chk({tag, "_good_count"}, int'(good_count), 0);
    chk({tag, "_bad_count"}, int'(bad_count), 0);
    chk({tag, "_measuring"}, int'(measuring), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_fault_code"}, int'(fault_code), 0);
  endtask

  initial begin
    do_reset(2);
    chk_zero("reset");

    // three ticks 4095 apart: two good periods
    push(4095, 1, 1, 0);
    push(4095, 1, 2, 0);
    ticks(3, 4095);
    chk("good_latency_valid", int'(period_valid), 1);
    chk("good_count", int'(good_count), 2);
    chk("good_fault", int'(fault), 0);
    chk("good_measuring", int'(measuring), 1);

    // short period followed by a back-to-back tick
    do_reset(2);
    push(100, 0, 0, 1);
    push(1, 0, 0, 2);
    ticks(2, 100);
    cyc(1'b1);
    chk("short_bad_count", int'(bad_count), 2);
    chk("short_good_count", int'(good_count), 0);
    chk("short_period_ok", int'(period_ok), 0);

    // timeout: cnt reaches 8191 after 8190 idle edges, faults on the next
    do_reset(2);
    cyc(1'b1);
    repeat (8190) cyc(1'b0);
    chk("pre_timeout_fault", int'(fault), 0);
    cyc(1'b0);
    chk("timeout_fault", int'(fault), 1);
    chk("timeout_code", int'(fault_code), 1);
    chk("timeout_measuring", int'(measuring), 0);
    cyc(1'b1);
    repeat (3) cyc(1'b0);
    chk("timeout_sticky", int'(fault), 1);
    chk("timeout_frozen_period", int'(period_out), 0);

    // stuck input held at zero
    do_reset(2);
    hold = 1'b1;
    lfsr_in = '0;
    repeat (15) cyc(1'b0);
    chk("stuck_15_fault", int'(fault), 0);
    cyc(1'b0);
`ifdef LFSR_MONITOR_STUCK_EN
    chk("stuck_16_fault", int'(fault), 1);
    chk("stuck_16_code", int'(fault_code), 2);
`else
    repeat (20) cyc(1'b0);
    chk("stuck_off_fault", int'(fault), 0);
    chk("stuck_off_code", int'(fault_code), 0);
`endif
    hold = 1'b0;

    // reset mid-measurement, coincident with a tick
    do_reset(2);
    push(100, 0, 0, 1);
    ticks(2, 100);
    repeat (2000) cyc(1'b0);
    reset = 1'b1;
    cyc(1'b1);
    reset = 1'b0;
    chk_zero("midreset");
    push(4095, 1, 1, 0);
    ticks(2, 4095);
    chk("midreset_good_count", int'(good_count), 1);

    // tick coincident with saturated counter
    do_reset(2);
    push(8191, 0, 0, 1);
    cyc(1'b1);
    repeat (8190) cyc(1'b0);
    cyc(1'b1);
    cyc(1'b0);
    chk("sat_tick_fault", int'(fault), 0);
    chk("sat_tick_measuring", int'(measuring), 1);
    chk("sat_tick_period", int'(period_out), 8191);

    // 300 bad periods saturate bad_count
    do_reset(2);
    for (int i = 1; i <= 300; i++) push(5, 0, 0, (i > 255) ? 255 : i);
    ticks(301, 5);
    cyc(1'b0);
    chk("bad_saturate", int'(bad_count), 255);
    chk("bad_saturate_good", int'(good_count), 0);

    repeat (3) cyc(1'b0);
    chk("scoreboard_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
